// File: rtl/inside_multi.sv
// inside_multi: sequential multi-jammer range checker.
// Holds a K-entry jammer table (x, y, radius). On an accepted start it checks
// point P against every entry in turn, using one shared squarer. For each
// entry it spends three cycles: it squares dx, then adds dy squared, then
// squares the radius and compares.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   we, waddr, wx/wy/wr table write; accepted only while idle
//   start, xP, yP       begin evaluation; P and jam_en are latched on accept
//   jam_en              per-entry enable, latched on accept
//   busy, done          busy during SQX/SQY/CMP; done is a one-cycle pulse
//   in_mask/in_count    per-entry hit mask and its popcount
//   any_in              OR of in_mask
//
// state | meaning
// IDLE  | waiting for start; table writes accepted
// SQX   | acc = (xP - xJ[k])^2
// SQY   | acc += (yP - yJ[k])^2
// CMP   | compare acc against rJ[k]^2, update mask bit k
// DONE  | one-cycle done pulse, results valid
module inside_multi #(
  parameter int N = 8,
  parameter int K = 4,
  localparam int KW = $clog2(K),
  localparam int CW = $clog2(K + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [KW-1:0]       waddr,
  input  logic signed [N-1:0] wx,
  input  logic signed [N-1:0] wy,
  input  logic [N:0]          wr,
  input  logic                start,
  input  logic signed [N+1:0] xP,
  input  logic signed [N+1:0] yP,
  input  logic [K-1:0]        jam_en,
  output logic                busy,
  output logic                done,
  output logic [K-1:0]        in_mask,
  output logic [CW-1:0]       in_count,
  output logic                any_in
);

  typedef enum logic [2:0] {IDLE, SQX, SQY, CMP, DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [KW-1:0]       k_q, k_d;
  logic [2*N+6:0]      acc_q, acc_d;
  logic signed [N+1:0] xp_q, xp_d, yp_q, yp_d;
  logic [K-1:0]        en_q, en_d;
  logic [K-1:0]        in_mask_q, in_mask_d;
  logic [CW-1:0]       in_count_q, in_count_d;
  logic                any_in_q, any_in_d;

  logic signed [N-1:0] xj_q [K];
  logic signed [N-1:0] xj_d [K];
  logic signed [N-1:0] yj_q [K];
  logic signed [N-1:0] yj_d [K];
  logic [N:0]          rj_q [K];
  logic [N:0]          rj_d [K];

  // Shared squarer. The operand is N+3 bits signed, and the product is taken
  // at 2N+6 bits so that (-2^(N+2))^2 still fits.
  logic signed [N+2:0]   sq_op;
  logic signed [2*N+5:0] sq_ext;
  logic signed [2*N+5:0] sq_mul;
  logic [2*N+5:0]        sq_prod;
  logic                  hit;

  assign sq_ext  = {{(N+3){sq_op[N+2]}}, sq_op};
  assign sq_mul  = sq_ext * sq_ext;
  assign sq_prod = sq_mul;

  function automatic logic [CW-1:0] popcnt(input logic [K-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < K; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  // Squarer operand select: dx in SQX, dy in SQY, zero-extended radius in CMP.
  always_comb begin
    sq_op = '0;
    case (state_q)
      SQX: sq_op = {xp_q[N+1], xp_q} - {{3{xj_q[k_q][N-1]}}, xj_q[k_q]};
      SQY: sq_op = {yp_q[N+1], yp_q} - {{3{yj_q[k_q][N-1]}}, yj_q[k_q]};
      CMP: sq_op = {2'b00, rj_q[k_q]};
      default: sq_op = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    k_d        = k_q;
    acc_d      = acc_q;
    xp_d       = xp_q;
    yp_d       = yp_q;
    en_d       = en_q;
    in_mask_d  = in_mask_q;
    in_count_d = in_count_q;
    any_in_d   = any_in_q;
    xj_d       = xj_q;
    yj_d       = yj_q;
    rj_d       = rj_q;
    hit        = 1'b0;
    case (state_q)
      IDLE: begin
        // The write lands at the same edge as start, so that evaluation sees it.
        if (we && (32'(waddr) < K)) begin
          xj_d[waddr] = wx;
          yj_d[waddr] = wy;
          rj_d[waddr] = wr;
        end
        if (start) begin
          xp_d       = xP;
          yp_d       = yP;
          en_d       = jam_en;
          in_mask_d  = '0;
          in_count_d = '0;
          any_in_d   = 1'b0;
          k_d        = '0;
          busy_d     = 1'b1;
          state_d    = SQX;
        end
      end
      SQX: begin
        acc_d   = {1'b0, sq_prod};
        state_d = SQY;
      end
      SQY: begin
        acc_d   = acc_q + {1'b0, sq_prod};
        state_d = CMP;
      end
      CMP: begin
        hit            = (acc_q <= {1'b0, sq_prod});
        in_mask_d[k_q] = hit & en_q[k_q];
        in_count_d     = popcnt(in_mask_d);
        any_in_d       = |in_mask_d;
        if (k_q == KW'(K - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = SQX;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      k_q        <= '0;
      acc_q      <= '0;
      xp_q       <= '0;
      yp_q       <= '0;
      en_q       <= '0;
      in_mask_q  <= '0;
      in_count_q <= '0;
      any_in_q   <= 1'b0;
      xj_q       <= '{default: '0};
      yj_q       <= '{default: '0};
      rj_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      en_q       <= en_d;
      in_mask_q  <= in_mask_d;
      in_count_q <= in_count_d;
      any_in_q   <= any_in_d;
      xj_q       <= xj_d;
      yj_q       <= yj_d;
      rj_q       <= rj_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_mask  = in_mask_q;
  assign in_count = in_count_q;
  assign any_in   = any_in_q;

endmodule

// File: tb/tb_inside_multi.sv
// Testbench for inside_multi: directed cases and randomized evaluations.
// Expected masks come from a plain-arithmetic distance model. The checks run
// through a queue that a separate monitor pops whenever done is seen.
module tb_inside_multi;
  localparam int N = 8;
  localparam int K = 4;
  localparam int KW = $clog2(K);
  localparam int CW = $clog2(K + 1);
  localparam int LAT = 3 * K + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                we = 1'b0;
  logic [KW-1:0]       waddr = '0;
  logic signed [N-1:0] wx = '0;
  logic signed [N-1:0] wy = '0;
  logic [N:0]          wr = '0;
  logic                start = 1'b0;
  logic signed [N+1:0] xP = '0;
  logic signed [N+1:0] yP = '0;
  logic [K-1:0]        jam_en = '0;
  logic                busy, done, any_in;
  logic [K-1:0]        in_mask;
  logic [CW-1:0]       in_count;

  inside_multi #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wx(wx), .wy(wy), .wr(wr),
    .start(start), .xP(xP), .yP(yP), .jam_en(jam_en),
    .busy(busy), .done(done), .in_mask(in_mask), .in_count(in_count), .any_in(any_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [K-1:0] mask; int c; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int mx[K], my[K], mr[K];
  logic [K-1:0] last_mask = '0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: squared Euclidean distance against squared radius, inclusive.
  function automatic logic [K-1:0] model(input int px, input int py, input logic [K-1:0] en);
    logic [K-1:0] m;
    longint d, r2;
    m = '0;
    for (int k = 0; k < K; k++) begin
      d  = longint'(px - mx[k]) * longint'(px - mx[k]) + longint'(py - my[k]) * longint'(py - my[k]);
      r2 = longint'(mr[k]) * longint'(mr[k]);
      m[k] = en[k] && (d <= r2);
    end
    return m;
  endfunction

  // Monitor: checks busy every cycle while a transaction is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb.size() > 0) begin
          e = sb[0];
          chk("busy", busy, (cyc > e.c) && (cyc < e.c + LAT));
          if (done) begin
            chk("latency", cyc - e.c, LAT);
            chk("in_mask", in_mask, e.mask);
            chk("in_count", in_count, $countones(e.mask));
            chk("any_in", any_in, |e.mask);
            void'(sb.pop_front());
          end else if (cyc > e.c + LAT) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
          end
        end else if (done) begin
          chk("unexpected_done", done, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tbl_write(input int a, input int x, input int y, input int r);
    @(negedge clk);
    we = 1'b1; waddr = KW'(a); wx = N'(x); wy = N'(y); wr = (N+1)'(r);
    mx[a] = x; my[a] = y; mr[a] = r;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Drive start at the current negedge and record the expected response.
  task automatic launch(input int x, input int y, input logic [K-1:0] en);
    exp_t e;
    start = 1'b1; xP = (N+2)'(x); yP = (N+2)'(y); jam_en = en;
    e.mask = model(x, y, en);
    e.c = cyc;
    last_mask = e.mask;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < LAT + 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      chk("wait_done", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    chk("hold_mask", in_mask, last_mask);
  endtask

  task automatic eval(input int x, input int y, input logic [K-1:0] en);
    @(negedge clk);
    launch(x, y, en);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic load_plan_table();
    tbl_write(0, -32, 108, 215);
    tbl_write(1, 109, -99, 183);
    tbl_write(2, -16, -111, 236);
    tbl_write(3, 0, 0, 5);
  endtask

  initial begin
    for (int k = 0; k < K; k++) begin mx[k] = 0; my[k] = 0; mr[k] = 0; end
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", in_mask, 0);
    chk("rst_count", in_count, 0);
    chk("rst_any", any_in, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load_plan_table();
    eval(-72, -102, 4'b1111);
    chk("plan_mask", in_mask, 4'b0111);

    // Reset in the middle of an evaluation.
    @(negedge clk);
    launch(-72, -102, 4'b1111);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mask", in_mask, 0);
    chk("midrst_count", in_count, 0);
    chk("midrst_any", any_in, 0);
    for (int k = 0; k < K; k++) begin mx[k] = 0; my[k] = 0; mr[k] = 0; end
    last_mask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    load_plan_table();
    eval(-72, -102, 4'b1111);

    eval(151, -276, 4'b1111);
    chk("out_j0", in_mask[0], 0);
    eval(-231, 5, 4'b1111);
    chk("out_j1", in_mask[1], 0);

    eval(3, 4, 4'b1111);
    chk("bnd_eq", in_mask[3], 1);
    tbl_write(3, 0, 0, 4);
    eval(3, 4, 4'b1111);
    chk("bnd_r4", in_mask[3], 0);
    tbl_write(3, 0, 0, 5);
    eval(3, 4, 4'b0111);
    chk("bnd_dis", in_mask[3], 0);

    for (int k = 0; k < K; k++) tbl_write(k, 127, 127, 511);
    eval(-512, -512, 4'b1111);
    eval(511, 511, 4'b1111);

    // Start held high through busy, with an ignored write while busy.
    load_plan_table();
    @(negedge clk);
    launch(-72, -102, 4'b1111);
    repeat (2) @(negedge clk);
    we = 1'b1; waddr = '0; wx = '0; wy = '0; wr = '0;
    @(negedge clk);
    we = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done();
    eval(-72, -102, 4'b1111);

    // Write and start together: the new entry is used.
    @(negedge clk);
    we = 1'b1; waddr = KW'(3); wx = '0; wy = '0; wr = (N+1)'(200);
    mx[3] = 0; my[3] = 0; mr[3] = 200;
    launch(-72, -102, 4'b1111);
    @(negedge clk);
    we = 1'b0; start = 1'b0;
    wait_done();
    chk("we_start_j3", in_mask[3], 1);

    for (int it = 0; it < 40; it++) begin
      int nw, px, py;
      logic [K-1:0] en;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        tbl_write($urandom_range(0, K - 1), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, $urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) begin
        px = int'($urandom_range(0, 1023)) - 512;
        py = int'($urandom_range(0, 1023)) - 512;
      end else begin
        px = int'($urandom_range(0, 300)) - 150;
        py = int'($urandom_range(0, 300)) - 150;
      end
      en = K'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        int a, x, y, r;
        a = $urandom_range(0, K - 1);
        x = int'($urandom_range(0, 255)) - 128;
        y = int'($urandom_range(0, 255)) - 128;
        r = $urandom_range(0, 511);
        @(negedge clk);
        we = 1'b1; waddr = KW'(a); wx = N'(x); wy = N'(y); wr = (N+1)'(r);
        mx[a] = x; my[a] = y; mr[a] = r;
        launch(px, py, en);
        @(negedge clk);
        we = 1'b0; start = 1'b0;
        wait_done();
      end else begin
        eval(px, py, en);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
